// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, parity mode codes and the
// elaboration-time parameter legality check used by both TX and RX.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    function automatic bit uart_params_ok(input int unsigned clks_per_bit,
                                          input int unsigned data_bits,
                                          input int unsigned parity_mode,
                                          input int unsigned stop_bits);
        return (clks_per_bit >= 2) && (clks_per_bit <= 65535) &&
               (data_bits >= 5) && (data_bits <= 9) &&
               (parity_mode <= PARITY_ODD) &&
               (stop_bits >= 1) && (stop_bits <= 2);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and strobes bit_end on the
// last cycle of each bit. restart holds the count at zero.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_end = !restart && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding register so that
// consecutive frames leave back-to-back without an idle gap.
module uart_tx_cfg import uart_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_TX_DV,
    input  logic [DATA_BITS-1:0] i_TX_Byte,
    output logic                 o_TX_Ready,
    output logic                 o_TX_Active,
    output logic                 o_TX_Serial,
    output logic                 o_TX_Done
);

    generate
        if (!uart_params_ok(CLKS_PER_BIT, DATA_BITS, PARITY_MODE, STOP_BITS)) begin : g_bad_params
            $error("uart_tx_cfg: illegal parameter combination");
        end
    endgenerate

    localparam int unsigned BitW = $clog2(DATA_BITS);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);
    localparam logic LastStop  = (STOP_BITS == 2);
    localparam logic HasParity = (PARITY_MODE != PARITY_NONE);
    localparam logic OddParity = (PARITY_MODE == PARITY_ODD);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 hold_valid_q, hold_valid_d;
    logic                 par_q, par_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
    logic                 bit_end;
    logic                 load;
    logic                 accept;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (i_Clock),
        .rst_n  (i_Rst_L),
        .restart(state_q == StIdle),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        shift_d      = shift_q;
        hold_valid_d = hold_valid_q;
        par_d        = par_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        done_d       = 1'b0;
        load         = 1'b0;
        accept       = i_TX_DV && ready_q;

        case (state_q)
            StIdle: begin
                if (hold_valid_q) begin
                    load    = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_cnt_q == LastBit) begin
                        state_d    = HasParity ? StParity : StStop;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d    = StStop;
                    stop_cnt_d = 1'b0;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (stop_cnt_q == LastStop) begin
                        done_d = 1'b1;
                        // A held byte chains straight into the next START.
                        if (hold_valid_q) begin
                            load    = 1'b1;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // load and accept are exclusive: accept needs ready, load needs hold_valid.
        if (load) begin
            shift_d      = hold_q;
            par_d        = (^hold_q) ^ OddParity;
            hold_valid_d = 1'b0;
        end else if (accept) begin
            hold_d       = i_TX_Byte;
            hold_valid_d = 1'b1;
        end
    end

    always_comb begin
        ready_d  = !hold_valid_d;
        active_d = (state_d != StIdle);
        case (state_d)
            StStart:  serial_d = 1'b0;
            StData:   serial_d = shift_d[0];
            StParity: serial_d = par_d;
            default:  serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            shift_q      <= '0;
            hold_valid_q <= 1'b0;
            par_q        <= 1'b0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            serial_q     <= 1'b1;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            hold_valid_q <= hold_valid_d;
            par_q        <= par_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            serial_q     <= serial_d;
            active_q     <= active_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
        end
    end

    assign o_TX_Ready  = ready_q;
    assign o_TX_Active = active_q;
    assign o_TX_Serial = serial_q;
    assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three configurations (8N1, 8E1, 7O2) share one stimulus
// stream and are checked every cycle against a frame-level model.
module tb_uart_tx_cfg;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       dv;
    logic [7:0] tx_byte;
    logic [2:0] ready, active, ser, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
        .o_TX_Ready(ready[0]), .o_TX_Active(active[0]), .o_TX_Serial(ser[0]), .o_TX_Done(done[0]));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
        .o_TX_Ready(ready[1]), .o_TX_Active(active[1]), .o_TX_Serial(ser[1]), .o_TX_Done(done[1]));

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u2 (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_TX_DV(dv), .i_TX_Byte(tx_byte[6:0]),
        .o_TX_Ready(ready[2]), .o_TX_Active(active[2]), .o_TX_Serial(ser[2]), .o_TX_Done(done[2]));

    function automatic int dbits(input int n);
        return (n == 2) ? 7 : 8;
    endfunction

    function automatic int pmode(input int n);
        return n;
    endfunction

    function automatic int sbits(input int n);
        return (n == 2) ? 2 : 1;
    endfunction

    function automatic int flen(input int n);
        return C * (1 + dbits(n) + ((pmode(n) != 0) ? 1 : 0) + sbits(n));
    endfunction

    // Line level for each bit slot of a frame, slot 0 = start bit.
    function automatic logic [15:0] build_frame(input int n, input logic [7:0] b);
        logic [15:0] f;
        int ones;
        f    = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < dbits(n); i++) begin
            f[1 + i] = b[i];
            ones     = ones + int'(b[i]);
        end
        if (pmode(n) != 0) f[1 + dbits(n)] = ((ones % 2) == 1) ^ (pmode(n) == 2);
        return f;
    endfunction

    task automatic chk(input string name, input int n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %0h want %0h", name, n, $time, got, exp);
        end
    endtask

    // Frame-level model: position inside the current frame plus a one-deep hold.
    bit          m_hv   [3];
    logic [7:0]  m_hold [3];
    logic [15:0] m_frame[3];
    int          m_pos  [3];
    bit          m_busy [3];
    bit          m_done [3];

    initial forever begin
        @(posedge clk or negedge rst_l);
        for (int n = 0; n < 3; n++) begin
            if (!rst_l) begin
                m_hv[n] = 0; m_busy[n] = 0; m_done[n] = 0; m_pos[n] = 0;
            end else begin
                bit acc;
                acc       = (dv === 1'b1) && !m_hv[n];
                m_done[n] = 0;
                if (m_busy[n]) begin
                    m_pos[n]++;
                    if (m_pos[n] == flen(n)) begin
                        m_done[n] = 1;
                        if (m_hv[n]) begin
                            m_frame[n] = build_frame(n, m_hold[n]);
                            m_pos[n]   = 0;
                            m_hv[n]    = 0;
                        end else begin
                            m_busy[n] = 0;
                        end
                    end
                end else if (m_hv[n]) begin
                    m_frame[n] = build_frame(n, m_hold[n]);
                    m_pos[n]   = 0;
                    m_busy[n]  = 1;
                    m_hv[n]    = 0;
                end
                if (acc) begin
                    m_hv[n]   = 1;
                    m_hold[n] = tx_byte;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            logic exp_ser;
            exp_ser = m_busy[n] ? m_frame[n][m_pos[n] / C] : 1'b1;
            chk("serial", n, 32'(ser[n]), 32'(exp_ser));
            chk("active", n, 32'(active[n]), 32'(m_busy[n]));
            chk("ready", n, 32'(ready[n]), 32'(!m_hv[n]));
            chk("done", n, 32'(done[n]), 32'(m_done[n]));
        end
    end

    logic cap_ser [3][140];
    logic cap_act [3][140];
    logic cap_done[3][140];

    // j = 0 is the cycle after the accepting edge; the frame starts at j = 1.
    task automatic send_capture(input logic [7:0] b, input int ncyc, input bit b2b,
                                output bit sent2);
        bit sent3;
        sent2 = 0;
        sent3 = 0;
        @(negedge clk);
        dv = 1'b1; tx_byte = b;
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                cap_ser[n][j] = ser[n]; cap_act[n][j] = active[n]; cap_done[n][j] = done[n];
            end
            dv = 1'b0;
            if (b2b) begin
                if (sent2 && !sent3) begin
                    dv = 1'b1; tx_byte = 8'h33; sent3 = 1;
                end else if (!sent2 && ready[0]) begin
                    dv = 1'b1; tx_byte = 8'h22; sent2 = 1;
                end
            end
        end
        dv = 1'b0;
    endtask

    task automatic check_frame(input int n, input logic [15:0] exp);
        logic [15:0] got;
        int L, dcnt, dfirst, acnt;
        L = flen(n);
        got = '0;
        for (int b = 0; b < L / C; b++) got[b] = cap_ser[n][3 + C * b];
        chk("frame_bits", n, 32'(got), 32'(exp));
        dcnt = 0; dfirst = -1; acnt = 0;
        for (int j = 0; j < 56; j++) begin
            if (cap_done[n][j] === 1'b1) begin
                dcnt++;
                if (dfirst < 0) dfirst = j;
            end
            if (cap_act[n][j] === 1'b1) acnt++;
        end
        chk("done_count", n, 32'(dcnt), 32'd1);
        chk("done_cycle", n, 32'(dfirst), 32'(L + 1));
        chk("active_cycles", n, 32'(acnt), 32'(L));
    endtask

    task automatic idle(input int ncyc);
        dv = 1'b0;
        repeat (ncyc) @(negedge clk);
    endtask

    initial begin
        bit sent2;
        int d1, d2, dcnt, acnt, lows;
        rst_l = 1'b1; dv = 1'b0; tx_byte = '0;
        #2 rst_l = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            chk("rst_serial", n, 32'(ser[n]), 32'd1);
            chk("rst_active", n, 32'(active[n]), 32'd0);
            chk("rst_ready", n, 32'(ready[n]), 32'd1);
            chk("rst_done", n, 32'(done[n]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        idle(3);

        send_capture(8'hA5, 56, 0, sent2);
        check_frame(0, 16'h034A);
        check_frame(1, 16'h054A);
        check_frame(2, 16'h064A);
        idle(10);
        send_capture(8'h07, 56, 0, sent2);
        check_frame(0, 16'h020E);
        check_frame(1, 16'h060E);
        check_frame(2, 16'h060E);
        idle(10);
        send_capture(8'h55, 56, 0, sent2);
        check_frame(0, 16'h02AA);
        check_frame(1, 16'h04AA);
        check_frame(2, 16'h07AA);
        idle(10);

        // Back-to-back 0x11 then 0x22, with 0x33 offered while full.
        send_capture(8'h11, 130, 1, sent2);
        chk("b2b_second_accepted", 0, 32'(sent2), 32'd1);
        d1 = -1; d2 = -1; dcnt = 0; acnt = 0;
        for (int j = 0; j < 130; j++) begin
            if (cap_done[0][j] === 1'b1) begin
                dcnt++;
                if (d1 < 0) d1 = j; else if (d2 < 0) d2 = j;
            end
            if (j >= 1 && j <= 80 && cap_act[0][j] === 1'b1) acnt++;
        end
        chk("b2b_done_count", 0, 32'(dcnt), 32'd2);
        chk("b2b_done_spacing", 0, 32'(d2 - d1), 32'd40);
        chk("b2b_active_held", 0, 32'(acnt), 32'd80);
        chk("b2b_last_stop", 0, 32'(cap_ser[0][40]), 32'd1);
        chk("b2b_next_start", 0, 32'(cap_ser[0][41]), 32'd0);
        idle(10);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            dv      = ((i % 600) < 120) ? 1'b1 : ($urandom_range(0, 3) == 0);
            tx_byte = 8'($urandom);
        end
        idle(100);

        // Reset in the middle of DATA with a byte waiting in the hold register.
        @(negedge clk); dv = 1'b1; tx_byte = 8'h5A;
        @(negedge clk); dv = 1'b0;
        @(negedge clk); dv = 1'b1; tx_byte = 8'h3C;
        @(negedge clk); dv = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", 0, 32'(active[0]), 32'd1);
        chk("pre_rst_held", 0, 32'(ready[0]), 32'd0);
        @(posedge clk);
        #2 rst_l = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            chk("midrst_serial", n, 32'(ser[n]), 32'd1);
            chk("midrst_active", n, 32'(active[n]), 32'd0);
            chk("midrst_ready", n, 32'(ready[n]), 32'd1);
            chk("midrst_done", n, 32'(done[n]), 32'd0);
        end
        @(negedge clk);
        rst_l = 1'b1;
        dcnt = 0; lows = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                if (done[n] !== 1'b0) dcnt++;
                if (ser[n] !== 1'b1) lows++;
            end
        end
        chk("post_rst_no_done", 0, 32'(dcnt), 32'd0);
        chk("post_rst_line_idle", 0, 32'(lows), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
